rs_syndrome_checker: RTL
========================

Name: rs_syndrome_checker

Overview:
- Receive-side front end of the Reed-Solomon path: consumes a codeword stream (message symbols first, then parity, in encoder output order) and computes the 16 syndromes over GF(2^8).
- Flags whether the codeword is error-free and hands the syndromes to the later key-equation/Chien stages.
- Shares the symbol field definition with the encoder: primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.

Parameters:
- N, 255, codeword length in symbols (17..255).
- NSYM, 16, number of syndromes/parity symbols; fixed at 16 in this revision.
- FCR, 0, first consecutive root exponent; syndrome i is evaluated at alpha^(FCR+i).

Ports:
- clkin  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- datain  input  8  received symbol.
- valid  input  1  datain is a live symbol this cycle.
- sof  input  1  qualifies valid: first symbol of a codeword.
- syn  output  128  syndromes; S_i at bits [8i+7:8i].
- done  output  1  one-cycle pulse, syn/err updated.
- err  output  1  at least one syndrome nonzero; held with syn.
- busy  output  1  frame in progress.
- err_cnt  output  16  erroneous-frame count (optional feature).

Behaviour:
- Reset (async, rst=1): state IDLE; accumulators, cnt, syn, err, done, busy, err_cnt all 0.
- States:
  - IDLE: waits for valid&sof.
  - ACCUM: accepts symbols.
  - Return to IDLE on frame completion.
- Accept rule: a symbol is consumed only when valid=1. Gaps (valid=0) freeze accumulators and cnt; there is no back-pressure.
- Horner update per accepted symbol r:
  - On the first symbol (sof): A_i <= r.
  - Otherwise: A_i <= A_i*alpha^(FCR+i) XOR r.
  - Constant multipliers are built as combinational XOR networks reduced by 0x11D.
- cnt counts accepted symbols 0..N-1. IDLE->ACCUM on valid&sof with cnt<=1; busy=1 while in ACCUM.
- Completion: when symbol number N-1 is accepted:
  - The next edge loads syn with the final A_i values (including that symbol).
  - err is set to the OR-reduce of the final values.
  - done=1 for exactly that one cycle; state returns to IDLE.
- Latency: done asserts 1 cycle after the last symbol's accepting edge.
- Back-to-back frames: sof on the cycle immediately after the last symbol is accepted normally. The following frame's done occurs N cycles later at the earliest.
- sof while in ACCUM: the partial frame is discarded without a done pulse, and the frame restarts with this symbol as symbol 0 (cnt<=1).
- valid without sof in IDLE: the symbol is ignored.
- syn/err hold their last values until the next done. They are not cleared at frame start.
- Reset mid-frame: the partial frame is lost and all outputs return to reset values immediately.
- Encoder parity convention: parity is q15 first ... q0 last. A clean encoder codeword yields syn==0 when FCR matches the generator roots.

Optional Feature:
- Macro: RS_ERRCNT_EN.
- Defined: err_cnt increments on every done with err=1. It saturates at 0xFFFF and is cleared only by rst.
- Undefined: no counter logic; err_cnt is tied to 16'h0000.

Test Plan:
- All-zero frame, N=255, FCR=0, valid continuous, sof on first symbol -> done on cycle 256 after sof; syn=0, err=0.
- Frame all zero except final symbol=0x01 -> every S_i=0x01, err=1. With RS_ERRCNT_EN, err_cnt=1.
- Frame all zero except symbol N-2=0x01 -> S_i=alpha^i: S0=01, S1=02, S2=04, S7=80, S8=1D, S9=3A, err=1.
- Same frame as the previous case, with valid dropped for 5 cycles at random points -> identical syn; done delayed by exactly 5 cycles.
- sof reasserted at symbol 100 of a corrupted frame, followed by a clean all-zero frame -> a single done only; syn=0, err=0.
- rst pulsed mid-frame after one erroneous frame -> syn, err, busy and err_cnt all 0 asynchronously; the next clean frame completes normally.
- Encoder-generated codeword with random message, fed in parity order q15..q0 -> syn=0. Flipping one byte -> err=1.

Source files
------------

// File: rtl/rs_syndrome_checker.sv
// Reed-Solomon receive front end: Horner evaluation of NSYM syndromes over GF(2^8), poly 0x11D.
// Optional erroneous-frame counter enabled by defining RS_ERRCNT_EN.
module rs_syndrome_checker #(
  parameter int unsigned N    = 255,
  parameter int unsigned NSYM = 16,
  parameter int unsigned FCR  = 0
) (
  input  logic               clkin,
  input  logic               rst,
  input  logic [7:0]         datain,
  input  logic               valid,
  input  logic               sof,
  output logic [8*NSYM-1:0]  syn,
  output logic               done,
  output logic               err,
  output logic               busy,
  output logic [15:0]        err_cnt
);

  localparam int unsigned CntW = $clog2(N);

  typedef enum logic {StIdle, StAccum} state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  // Column b of the matrix is alpha^e * x^b, so a product is an XOR of selected columns.
  function automatic logic [63:0] mul_matrix(input int unsigned e);
    logic [7:0]  p;
    logic [63:0] m;
    p = 8'h01;
    for (int unsigned k = 0; k < (e % 255); k++) p = gf_xtime(p);
    for (int unsigned b = 0; b < 8; b++) begin
      m[8*b +: 8] = p;
      p = gf_xtime(p);
    end
    return m;
  endfunction

  function automatic logic [7:0] mul_by(input logic [7:0] a, input logic [63:0] m);
    logic [7:0] r;
    r = 8'h00;
    for (int unsigned b = 0; b < 8; b++) begin
      if (a[b]) r = r ^ m[8*b +: 8];
    end
    return r;
  endfunction

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [NSYM-1:0][7:0]       acc_q, acc_d;
  logic [NSYM-1:0][7:0]       horner;
  logic                       last_q, last_d;
  logic [8*NSYM-1:0]          syn_q, syn_d;
  logic                       err_q, err_d;
  logic                       done_q, done_d;

  for (genvar i = 0; i < NSYM; i++) begin : g_mul
    localparam logic [63:0] MulM = mul_matrix(FCR + i);
    assign horner[i] = mul_by(acc_q[i], MulM);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    last_d  = 1'b0;
    syn_d   = syn_q;
    err_d   = err_q;
    done_d  = 1'b0;
    // Publish one cycle after the last symbol; a new frame may load acc in the same edge.
    if (last_q) begin
      syn_d  = acc_q;
      err_d  = |acc_q;
      done_d = 1'b1;
    end
    if (valid && sof) begin
      acc_d   = {NSYM{datain}};
      cnt_d   = CntW'(1);
      state_d = StAccum;
    end else if (valid && (state_q == StAccum)) begin
      for (int i = 0; i < NSYM; i++) acc_d[i] = horner[i] ^ datain;
      if (cnt_q == CntW'(N - 1)) begin
        state_d = StIdle;
        cnt_d   = '0;
        last_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      last_q  <= 1'b0;
      syn_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      last_q  <= last_d;
      syn_q   <= syn_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign syn  = syn_q;
  assign err  = err_q;
  assign done = done_q;
  assign busy = (state_q == StAccum);

`ifdef RS_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (last_q && (|acc_q) && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule
